// File: rtl/stage_scheduler_pkg.sv
// Shared types and constants for the pipeline stage scheduler.
// Holds the state encoding, error causes and well-known stage indices.
package stage_scheduler_pkg;

    localparam int NUM_STAGES_MAX = 16;
    localparam int IDX_W          = $clog2(NUM_STAGES_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAUSE_SPURIOUS = 2'd2;

    localparam logic [IDX_W-1:0] STAGE_FIRST         = 4'd0;
    localparam logic [IDX_W-1:0] STAGE_SORT_SEQUENCE = 4'd9;

endpackage

// File: rtl/stage_scheduler_if.sv
// Stage-side bus between the scheduler and the per-stage controllers.
// stage_start is a one-cycle launch pulse; stage_end is a level a stage raises when finished
// and may keep high afterwards; ram_owner grants the shared RAMs while the stage is launched/running.
interface stage_scheduler_if #(
    parameter int NUM_STAGES = 10
);
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_end;
    logic [NUM_STAGES-1:0] ram_owner;

    modport master (
        output stage_start,
        output ram_owner,
        input  stage_end
    );

    modport slave (
        input  stage_start,
        input  ram_owner,
        output stage_end
    );
endinterface

// File: rtl/stage_scheduler_next_stage_finder.sv
// Combinational search for the first unmasked stage at or after a start index.
// A start beyond the last stage reports not-found; the search never wraps.
module next_stage_finder #(
    parameter int NUM_STAGES = 10
) (
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic [4:0]            start,
    output logic [3:0]            index,
    output logic                  found
);
    always_comb begin
        index = '0;
        found = 1'b0;
        // Walk downwards so the lowest qualifying index is the one left standing.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if ((5'(k) >= start) && !skip_mask[k]) begin
                index = 4'(k);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stage_scheduler.sv
// Sequences the pipeline stages in order, grants shared-RAM ownership to the active stage,
// skips masked stages and traps hung (timeout) or out-of-order (spurious end) stages.
module stage_scheduler
    import stage_scheduler_pkg::*;
#(
    parameter int NUM_STAGES     = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  program_reset,
    input  logic                  start_program,
    input  logic [NUM_STAGES-1:0] skip_mask,
    stage_scheduler_if.master     bus,
    output logic [IDX_W-1:0]      current_stage,
    output logic                  busy,
    output logic                  program_done,
    output logic                  error,
    output logic [IDX_W-1:0]      error_stage,
    output logic [1:0]            error_cause,
    output state_t                state
);
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t                next_state;
    logic [IDX_W-1:0]      idx, next_idx;
    logic [19:0]           watchdog;
    logic [1:0]            next_cause;
    logic [4:0]            find_start;
    logic [IDX_W-1:0]      find_index;
    logic                  find_found;
    logic [NUM_STAGES-1:0] later_mask;
    logic [NUM_STAGES-1:0] cur_onehot;
    logic [NUM_STAGES-1:0] next_onehot;

    next_stage_finder #(.NUM_STAGES(NUM_STAGES)) u_finder (
        .skip_mask (skip_mask),
        .start     (find_start),
        .index     (find_index),
        .found     (find_found)
    );

    // IDLE searches from stage 0; ADVANCE searches strictly after the finished stage.
    assign find_start  = (state == S_ADVANCE) ? (5'(idx) + 5'd1) : 5'd0;
    assign cur_onehot  = NUM_STAGES'(1) << idx;
    assign next_onehot = NUM_STAGES'(1) << next_idx;

    always_comb begin
        later_mask = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            later_mask[j] = (4'(j) > idx);
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_cause = CAUSE_NONE;
        case (state)
            S_IDLE: begin
                if (start_program) begin
                    next_idx   = find_index;
                    next_state = find_found ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH: next_state = S_WAIT;
            S_WAIT: begin
                // Finished stages may hold their end high, so only later stages count as spurious.
                if (|(bus.stage_end & later_mask)) begin
                    next_state = S_ERROR;
                    next_cause = CAUSE_SPURIOUS;
                end else if (watchdog == WD_LAST) begin
                    next_state = S_ERROR;
                    next_cause = CAUSE_TIMEOUT;
                end else if (|(bus.stage_end & cur_onehot)) begin
                    next_state = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (find_found) begin
                    next_idx   = find_index;
                    next_state = S_LAUNCH;
                end else begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  if (!start_program) next_state = S_IDLE;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (program_reset) begin
            state           <= S_IDLE;
            idx             <= '0;
            watchdog        <= '0;
            bus.stage_start <= '0;
            bus.ram_owner   <= '0;
            current_stage   <= '0;
            busy            <= 1'b0;
            program_done    <= 1'b0;
            error           <= 1'b0;
            error_stage     <= '0;
            error_cause     <= CAUSE_NONE;
        end else begin
            state           <= next_state;
            idx             <= next_idx;
            // Zero through LAUNCH, then counts WAIT cycles so the trap lands TIMEOUT_CYCLES after launch.
            watchdog        <= (next_state == S_WAIT) ? (watchdog + 20'd1) : '0;
            bus.stage_start <= (next_state == S_LAUNCH) ? next_onehot : '0;
            bus.ram_owner   <= (next_state inside {S_LAUNCH, S_WAIT}) ? next_onehot : '0;
            current_stage   <= (next_state == S_IDLE) ? '0 : next_idx;
            busy            <= (next_state inside {S_LAUNCH, S_WAIT, S_ADVANCE});
            program_done    <= (next_state == S_DONE);
            error           <= (next_state == S_ERROR);
            if ((state == S_WAIT) && (next_state == S_ERROR)) begin
                error_stage <= idx;
                error_cause <= next_cause;
            end
        end
    end
endmodule

// File: tb/tb_stage_scheduler.sv
// Bench for stage_scheduler: a per-run timeline is planned from the sequencing rules,
// stage_end is driven from that plan, and every cycle's outputs are compared with it.
module tb_stage_scheduler;
    import stage_scheduler_pkg::*;

    localparam int N    = 10;
    localparam int T    = 16;
    localparam int MAXC = 400;

    logic         clk = 1'b0;
    logic         program_reset;
    logic         start_program;
    logic [N-1:0] skip_mask;
    logic [3:0]   current_stage;
    logic         busy;
    logic         program_done;
    logic         error;
    logic [3:0]   error_stage;
    logic [1:0]   error_cause;
    state_t       state;

    stage_scheduler_if #(.NUM_STAGES(N)) bus ();

    stage_scheduler #(.NUM_STAGES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .program_reset (program_reset),
        .start_program (start_program),
        .skip_mask     (skip_mask),
        .bus           (bus.master),
        .current_stage (current_stage),
        .busy          (busy),
        .program_done  (program_done),
        .error         (error),
        .error_stage   (error_stage),
        .error_cause   (error_cause),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] start;
        logic [N-1:0] owner;
        logic [3:0]   cs;
        logic         busy;
        logic         done;
        logic         err;
        logic [3:0]   es;
        logic [1:0]   ec;
    } obs_t;

    typedef struct {
        logic [N-1:0] mask;
        int           d;
        int           exp_starts;
        int           exp_done;
        int           exp_last;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    obs_t       exp_v[MAXC];
    logic [N-1:0] end_v[MAXC];
    int         dly[N];
    int         run_len;
    int         n_starts, done_cyc, done_cs, err_cyc;
    vec_t       vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.start = bus.stage_start;
        o.owner = bus.ram_owner;
        o.cs    = current_stage;
        o.busy  = busy;
        o.done  = program_done;
        o.err   = error;
        o.es    = error_stage;
        o.ec    = error_cause;
        return o;
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [N-1:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < N; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic do_reset(input string tag);
        obs_t o;
        program_reset = 1'b1;
        start_program = 1'b0;
        bus.stage_end = '0;
        step();
        program_reset = 1'b0;
        o = sample();
        check({tag, "_reset_outputs"}, 64'(o), 64'(0));
        check({tag, "_reset_state"}, 64'(state), 64'(S_IDLE));
    endtask

    // Plans one run from the rules, then drives it and compares cycle by cycle.
    task automatic run_plan(input logic [N-1:0] mask, input int sp_stage, input int sp_j,
                            input int sp_e, input int stop_at, input string tag);
        int   t_next, last_s, err_c, lim;
        bit   any, err_exp;
        obs_t o;
        for (int c = 0; c < MAXC; c++) begin
            exp_v[c] = '0;
            end_v[c] = '0;
        end
        exp_q.delete();
        t_next = 1; last_s = 0; err_c = 0; any = 0; err_exp = 0;
        for (int s = 0; s < N && !err_exp; s++) begin
            if (!mask[s]) begin
                int l_c, own_end, cause;
                l_c = t_next;
                cause = 0;
                exp_q.push_back(4'(s));
                exp_v[l_c].start = N'(1) << s;
                if (s == sp_stage) begin
                    own_end = l_c + sp_e;
                    err_exp = 1; err_c = own_end + 1; cause = 2;
                    end_v[l_c + sp_e][sp_j] = 1'b1;
                end else if (dly[s] <= T - 2) begin
                    own_end = l_c + dly[s];
                end else begin
                    own_end = l_c + T - 1;
                    err_exp = 1; err_c = l_c + T; cause = 1;
                end
                for (int c = l_c + dly[s]; c < MAXC; c++) end_v[c][s] = 1'b1;
                for (int c = l_c; c <= own_end; c++) begin
                    exp_v[c].owner = N'(1) << s;
                    exp_v[c].cs    = 4'(s);
                    exp_v[c].busy  = 1'b1;
                end
                if (err_exp) begin
                    for (int c = err_c; c < err_c + 4; c++) begin
                        exp_v[c].err = 1'b1;
                        exp_v[c].es  = 4'(s);
                        exp_v[c].ec  = 2'(cause);
                        exp_v[c].cs  = 4'(s);
                    end
                end else begin
                    exp_v[own_end + 1].busy = 1'b1;
                    exp_v[own_end + 1].cs   = 4'(s);
                    t_next = own_end + 2;
                    last_s = s;
                    any    = 1;
                end
            end
        end
        if (err_exp) begin
            run_len = err_c + 4;
        end else begin
            exp_v[t_next].done = 1'b1;
            exp_v[t_next].cs   = any ? 4'(last_s) : 4'd0;
            run_len = t_next + 2;
        end
        lim = (stop_at >= 0) ? stop_at : run_len;
        n_starts = 0; done_cyc = -1; done_cs = 0; err_cyc = -1;
        for (int t = 0; t < lim; t++) begin
            o = sample();
            check($sformatf("%s_cycle%0d", tag, t), 64'(o), 64'(exp_v[t]));
            if (o.start != '0) begin
                n_starts++;
                if (exp_q.size() == 0) check({tag, "_start_extra"}, 64'(o.start), 64'(0));
                else check({tag, "_start_order"}, 64'(onehot_idx(o.start)), 64'(exp_q.pop_front()));
            end
            if (o.done && done_cyc < 0) begin
                done_cyc = t;
                done_cs  = int'(o.cs);
            end
            if (o.err && err_cyc < 0) err_cyc = t;
            start_program = (t == 0);
            skip_mask     = mask;
            bus.stage_end = end_v[t];
            step();
        end
        if (stop_at < 0) check({tag, "_starts_missing"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        bus.stage_end = '0;
        if (err_exp && stop_at < 0) do_reset(tag);
    endtask

    initial begin
        int m_sp_stage, m_sp_j, m_sp_e;
        logic [N-1:0] m_mask;

        vecs[0] = '{10'h000, 5, 10, 71, 9};
        vecs[1] = '{10'h155, 5, 5, 36, 9};
        vecs[2] = '{10'h3FF, 5, 0, 1, 0};
        vecs[3] = '{10'h2AA, 5, 5, 36, 8};
        vecs[4] = '{10'h1FF, 3, 1, 6, 9};
        vecs[5] = '{10'h000, 14, 10, 161, 9};
        vecs[6] = '{10'h3FE, 1, 1, 4, 0};

        program_reset = 1'b1;
        start_program = 1'b0;
        skip_mask     = '0;
        bus.stage_end = '0;
        do_reset("init");

        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < N; s++) dly[s] = vecs[i].d;
            run_plan(vecs[i].mask, -1, 0, 0, -1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_starts", i), 64'(n_starts), 64'(vecs[i].exp_starts));
            check($sformatf("vec%0d_done_cycle", i), 64'(done_cyc), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_last_stage", i), 64'(done_cs), 64'(vecs[i].exp_last));
        end

        // Stage 2 never ends: trap 16 cycles after its launch at cycle 15.
        for (int s = 0; s < N; s++) dly[s] = 5;
        dly[2] = 1000;
        run_plan('0, -1, 0, 0, -1, "timeout");
        check("timeout_cycle", 64'(err_cyc), 64'(31));

        // End arriving on the same edge as the timeout still loses to the timeout.
        for (int s = 0; s < N; s++) dly[s] = 5;
        dly[0] = T - 1;
        run_plan('0, -1, 0, 0, -1, "timeout_edge");
        check("timeout_edge_cycle", 64'(err_cyc), 64'(17));

        // Stage 6 pulses on the same edge stage 3 ends; stage 1 holds its end high.
        for (int s = 0; s < N; s++) dly[s] = 5;
        run_plan('0, 3, 6, 5, -1, "spurious");
        check("spurious_cycle", 64'(err_cyc), 64'(28));

        // Reset while stage 4 is in WAIT, then a fresh start begins from stage 0.
        run_plan('0, -1, 0, 0, 32, "midreset");
        do_reset("midreset");
        run_plan('0, -1, 0, 0, -1, "restart");
        check("restart_starts", 64'(n_starts), 64'(10));
        check("restart_done_cycle", 64'(done_cyc), 64'(71));

        for (int r = 0; r < 12; r++) begin
            m_mask = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            for (int s = 0; s < N; s++)
                dly[s] = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T) : $urandom_range(1, 10);
            m_sp_stage = -1; m_sp_j = 0; m_sp_e = 0;
            if ($urandom_range(0, 4) == 0) begin
                for (int s = 0; s < N - 1; s++)
                    if (!m_mask[s] && m_sp_stage < 0 && $urandom_range(0, 2) == 0) m_sp_stage = s;
                if (m_sp_stage >= 0) begin
                    m_sp_j = $urandom_range(m_sp_stage + 1, N - 1);
                    m_sp_e = $urandom_range(1, (dly[m_sp_stage] < T - 1) ? dly[m_sp_stage] : T - 1);
                end
            end
            run_plan(m_mask, m_sp_stage, m_sp_j, m_sp_e, -1, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stage_scheduler.md
# stage_scheduler

Top-level sequencer for the multi-stage processing pipeline: launches each stage controller (such as sort-sequence) in order by pulsing its start_process and waiting for its end_process. It grants exclusive ownership of the shared RAMs (nodeHeads, nodeSeq, elementSeq) to the active stage, skips masked stages, and watches for hung or misbehaving stages. It sits between the FPGA key and switch inputs and the per-stage controllers.

## Interface
- NUM_STAGES, 10, number of sequenced stages; maximum 16.
- TIMEOUT_CYCLES, 1000000, watchdog limit per stage in clk cycles; the counter is 20 bits wide.
- clk  in  1  system clock; all logic is on the rising edge.
- program_reset  in  1  synchronous, active-high reset, driven from ~KEY[0].
- start_program  in  1  level request to run the pipeline; sampled in IDLE and DONE.
- skip_mask  in  NUM_STAGES  bit k=1 means stage k is bypassed; sampled in IDLE and ADVANCE.
- stage_end  in  NUM_STAGES  end_process level from each stage.
- stage_start  out  NUM_STAGES  one-hot, one-cycle start_process pulse.
- ram_owner  out  NUM_STAGES  one-hot select for the shared-RAM mux; all zero means no owner.
- current_stage  out  4  index of the stage being launched or run.
- busy  out  1  high in LAUNCH, WAIT and ADVANCE.
- program_done  out  1  high in DONE.
- error  out  1  high in ERROR; sticky.
- error_stage  out  4  stage index at the time of the error.
- error_cause  out  2  0 = none, 1 = timeout, 2 = spurious end.

## Operation
- States: IDLE, LAUNCH, WAIT, ADVANCE, DONE, ERROR. All outputs are registered.
- Reset (program_reset=1 at an edge):
  - State goes to IDLE; every output goes to 0 and idx goes to 0.
  - Reset overrides every other state, including mid-stage.
  - The running stage receives no further start pulse. Resetting the stage itself is the stages' own concern.
- IDLE, when start_program=1:
  - idx = first k with skip_mask[k]=0.
  - If such a k exists, go to LAUNCH; if every stage is masked, go to DONE.
- LAUNCH, one cycle:
  - stage_start[idx]=1, ram_owner[idx]=1, current_stage=idx.
  - The watchdog is cleared. Go to WAIT.
- WAIT:
  - ram_owner[idx] stays high and the watchdog increments every cycle.
  - Checks run in priority order:
    - stage_end[j]=1 for any j>idx (a not-yet-launched stage): go to ERROR, cause 2.
    - Otherwise, watchdog == TIMEOUT_CYCLES-1: go to ERROR, cause 1.
    - Otherwise, stage_end[idx]=1: go to ADVANCE.
  - stage_end[j] for j<idx is ignored, because finished stages may hold end_process high.
- ADVANCE, one cycle:
  - ram_owner is all zero, giving one bus-turnaround cycle.
  - idx = first k>idx with skip_mask[k]=0. If one exists, go to LAUNCH; otherwise go to DONE.
- DONE:
  - program_done=1 and ram_owner=0.
  - When start_program=0, go to IDLE. A start_program still held high does not relaunch.
- ERROR:
  - error=1; error_stage and error_cause are frozen; ram_owner=0.
  - Only program_reset exits this state.
- current_stage keeps the last idx in DONE and ERROR. It is 0 in IDLE.
- Stage indices are 4-bit unsigned. The search never wraps past NUM_STAGES-1.

## Timing
- Stage k's start pulse is visible in the cycle after start_program is sampled high in IDLE.
- stage_end is sampled only in WAIT, so a stage needs at least 1 cycle from its start pulse before it can end.
- stage_end[idx] sampled at edge t gives: ADVANCE in the t+1 cycle, then the next stage_start in the t+2 cycle. That is a fixed 2-cycle gap.
- Timeout: ERROR is entered TIMEOUT_CYCLES cycles after LAUNCH, provided no end arrives.
- A spurious end on the same edge as a valid end or a timeout resolves to ERROR cause 2.
- A skip_mask change during WAIT takes effect at the next ADVANCE.

## Structure
- The shared package holds:
  - the state encoding enum;
  - the error-cause constants (NONE=0, TIMEOUT=1, SPURIOUS=2);
  - the stage-index constants (for example STAGE_SORT_SEQUENCE=9);
  - NUM_STAGES_MAX=16.
- One sub-module, next_stage_finder: combinational. Given skip_mask and a start index, it returns the first unmasked index ≥ start plus a found flag. It is used by both IDLE and ADVANCE.
- The FSM, idx register, watchdog counter and error registers live in stage_scheduler.

## Test plan
- Normal run, skip_mask=0, each stage ends 5 cycles after its start:
  - stage_start pulses occur at k=0..9 in order, 7 cycles apart.
  - ram_owner is one-hot matching, and zero in each ADVANCE cycle.
  - program_done=1 after stage 9.
- skip_mask=10'b0101010101: only stages 1, 3, 5, 7, 9 start, with a 2-cycle gap after each end.
- skip_mask=all ones: DONE one cycle after start_program, and no stage_start pulses.
- TIMEOUT_CYCLES=16, stage 2 never ends:
  - ERROR exactly 16 cycles after its LAUNCH.
  - error_stage=2, error_cause=1, ram_owner=0.
- Spurious end while stage 3 runs:
  - stage_end[6] pulses, with stage_end[3] high on the same edge: ERROR, cause 2, error_stage=3.
  - stage_end[1] held high throughout causes no error.
- Reset mid-WAIT on stage 4: all outputs are 0 in the next cycle and the state is IDLE. start_program=1 then restarts from stage 0.
